alu_seq: RTL and testbench

Parametrised, handshaked successor to the processor's combinational ALU. It keeps the existing 6-bit opcode map and the `Z`/`CMP_Flag` result pair, and adds the following:
- configurable data width;
- registered outputs with valid/ready flow control;
- an iterative multiplier, so wide multiplies do not set the critical path;
- signed compare, minimum and arithmetic-shift operations.

It sits between the decode stage and writeback/branch logic of the filter processor.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mul_iter.sv | 67 ++++++
 rtl/alu_seq.sv | 137 +++++++++++++
 tb/tb_alu_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode map and control-state encoding shared by the ALU and the decode stage.
package alu_pkg;

    localparam logic [5:0] OP_ADD      = 6'b000000;
    localparam logic [5:0] OP_SUB      = 6'b000001;
    localparam logic [5:0] OP_MUL      = 6'b000010;
    localparam logic [5:0] OP_AND      = 6'b000011;
    localparam logic [5:0] OP_OR       = 6'b000100;
    localparam logic [5:0] OP_XOR      = 6'b000101;
    localparam logic [5:0] OP_NOT      = 6'b000110;
    localparam logic [5:0] OP_MAX      = 6'b000111;
    localparam logic [5:0] OP_SLL      = 6'b001000;
    localparam logic [5:0] OP_SRL      = 6'b001001;
    localparam logic [5:0] OP_SRA      = 6'b001010;
    localparam logic [5:0] OP_MIN      = 6'b001011;
    localparam logic [5:0] OP_CMP_LE   = 6'b111010;
    localparam logic [5:0] OP_CMP_EQ   = 6'b101011;
    localparam logic [5:0] OP_CMP_LT   = 6'b011011;
    localparam logic [5:0] OP_CMP_LT_S = 6'b011100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: MUL_STEP multiplier bits per cycle, low WIDTH
// bits of the product, one-cycle done pulse K cycles after start.
module alu_mul_iter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int unsigned K  = WIDTH / MUL_STEP;
    localparam int unsigned CW = $clog2(K + 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] partial;
    logic [CW-1:0]    cnt;
    logic             running;

    always_comb begin
        partial = '0;
        for (int unsigned j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                partial = partial + (mcand << j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                acc     <= '0;
                mcand   <= a;
                mplier  <= b;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                // Bits shifted past WIDTH are dropped, giving the product modulo 2^WIDTH.
                acc    <= acc + partial;
                mcand  <= mcand << MUL_STEP;
                mplier <= mplier >> MUL_STEP;
                cnt    <= cnt + CW'(1);
                if (cnt == CW'(K - 1)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

    assign p = acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flag, iterative multiply and a
// three-state control FSM (IDLE, MUL, HOLD).
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_STEP = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       code,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Z,
    output logic             CMP_Flag,
    output logic             busy
);

    localparam int unsigned SW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_p;
    logic             load_alu;
    logic             load_mul;
    logic [WIDTH-1:0] alu_z;
    logic             alu_cmp;
    logic             y_big;
    logic [SW-1:0]    sh;

    alu_mul_iter #(
        .WIDTH   (WIDTH),
        .MUL_STEP(MUL_STEP)
    ) u_mul (
        .clk  (clk),
        .rst_n(rst_n),
        .start(mul_start),
        .a    (X),
        .b    (Y),
        .done (mul_done),
        .p    (mul_p)
    );

    // Out-of-range shift amounts are judged on the whole Y, not its low bits.
    assign y_big = (Y >= WIDTH'(WIDTH));
    assign sh    = Y[SW-1:0];

    always_comb begin
        alu_z   = '0;
        alu_cmp = 1'b0;
        case (code)
            OP_ADD:      alu_z = X + Y;
            OP_SUB:      alu_z = X - Y;
            OP_AND:      alu_z = X & Y;
            OP_OR:       alu_z = X | Y;
            OP_XOR:      alu_z = X ^ Y;
            OP_NOT:      alu_z = ~Y;
            OP_MAX:      alu_z = (X > Y) ? X : Y;
            OP_MIN:      alu_z = (X < Y) ? X : Y;
            OP_SLL:      alu_z = y_big ? '0 : (X << sh);
            OP_SRL:      alu_z = y_big ? '0 : (X >> sh);
            OP_SRA:      alu_z = y_big ? {WIDTH{X[WIDTH-1]}} : WIDTH'($signed(X) >>> sh);
            OP_CMP_LE:   alu_cmp = (X <= Y);
            OP_CMP_EQ:   alu_cmp = (X == Y);
            OP_CMP_LT:   alu_cmp = (X < Y);
            OP_CMP_LT_S: alu_cmp = ($signed(X) < $signed(Y));
            default:     ;
        endcase
    end

    assign in_ready = rst_n && ((state == IDLE) || ((state == HOLD) && out_ready));
    assign accept   = in_valid && in_ready;
    assign busy     = (state == MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mul_start  = 1'b0;
        load_alu   = 1'b0;
        load_mul   = 1'b0;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    if (code == OP_MUL) begin
                        mul_start  = 1'b1;
                        next_state = MUL;
                    end else begin
                        load_alu   = 1'b1;
                        next_state = HOLD;
                    end
                end else if ((state == HOLD) && out_ready) begin
                    next_state = IDLE;
                end
            end
            MUL: begin
                if (mul_done) begin
                    load_mul   = 1'b1;
                    next_state = HOLD;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Z         <= '0;
            CMP_Flag  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_alu) begin
            Z         <= alu_z;
            CMP_Flag  <= alu_cmp;
            out_valid <= 1'b1;
        end else if (load_mul) begin
            Z         <= mul_p;
            CMP_Flag  <= 1'b0;
            out_valid <= 1'b1;
        end else if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and randomized checks of alu_seq at 32/1 and 16/4 parameterisations.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        in_valid, in_ready, out_valid, out_ready, CMP_Flag, busy;
    logic [5:0]  code;
    logic [31:0] X, Y, Z;

    logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h, cmp_h, busy_h;
    logic [5:0]  code_h;
    logic [15:0] x_h, y_h, z_h;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(32), .MUL_STEP(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .code(code), .X(X), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
        .Z(Z), .CMP_Flag(CMP_Flag), .busy(busy)
    );

    alu_seq #(.WIDTH(16), .MUL_STEP(4)) dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
        .code(code_h), .X(x_h), .Y(y_h), .out_valid(out_valid_h), .out_ready(out_ready_h),
        .Z(z_h), .CMP_Flag(cmp_h), .busy(busy_h)
    );

    // Present a request and wait (bounded) until it is accepted; returns #1 after the accepting edge.
    task automatic issue(input logic [5:0] c, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        code = c; X = a; Y = b; in_valid = 1'b1;
        #1;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; code = '0; X = '0; Y = '0;
        in_valid_h = 1'b0; out_ready_h = 1'b0; code_h = '0; x_h = '0; y_h = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, out_valid, CMP_Flag, busy} !== 4'b0000 || Z !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b ov=%b cmp=%b busy=%b Z=%h required all 0",
                     in_ready, out_valid, CMP_Flag, busy, Z);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        issue(6'b000000, 32'hFFFF_FFFF, 32'h1);
        checks++;
        if (out_valid !== 1'b1 || Z !== 32'h0 || CMP_Flag !== 1'b0) begin
            errors++;
            $display("FAIL add_wrap: ov=%b Z=%h cmp=%b required 1 00000000 0", out_valid, Z, CMP_Flag);
        end
        issue(6'b000110, 32'h1234_5678, 32'h0);
        checks++;
        if (out_valid !== 1'b1 || Z !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL not_y: ov=%b Z=%h required 1 ffffffff", out_valid, Z);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_mul_latency();
        int lat = 0;
        bit rdy_bad = 0;
        bit busy_bad = 0;
        out_ready = 1'b1;
        issue(6'b000010, 32'h0001_0000, 32'h0001_0001);
        // A second request stays valid throughout the multiply.
        code = 6'b000000; X = 32'd1; Y = 32'd2; in_valid = 1'b1;
        while (lat < 100) begin
            @(posedge clk); #1; lat++;
            if (out_valid === 1'b1) break;
            if (in_ready !== 1'b0) rdy_bad = 1;
            if (busy !== 1'b1) busy_bad = 1;
        end
        checks++;
        if (lat != 33 || Z !== 32'h0001_0000 || CMP_Flag !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: latency=%0d Z=%h cmp=%b required 33 00010000 0", lat, Z, CMP_Flag);
        end
        checks++;
        if (rdy_bad || busy_bad) begin
            errors++;
            $display("FAIL mul_backpressure: ready_seen_high=%0d busy_seen_low=%0d required 0 0", rdy_bad, busy_bad);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Z !== 32'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL queued_add: ov=%b Z=%h busy=%b required 1 00000003 0", out_valid, Z, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        bit bad = 0;
        out_ready = 1'b0;
        issue(6'b011011, 32'd3, 32'd5);
        X = 32'hDEAD; Y = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid !== 1'b1 || CMP_Flag !== 1'b1 || Z !== 32'h0 || in_ready !== 1'b0) bad = 1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL stall_hold: ov=%b cmp=%b Z=%h rdy=%b required 1 1 00000000 0",
                     out_valid, CMP_Flag, Z, in_ready);
        end
        out_ready = 1'b1; code = 6'b000001; X = 32'd7; Y = 32'd9; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_from_out_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || Z !== 32'hFFFF_FFFE || CMP_Flag !== 1'b0) begin
            errors++;
            $display("FAIL sub_after_stall: ov=%b Z=%h cmp=%b required 1 fffffffe 0", out_valid, Z, CMP_Flag);
        end
        @(posedge clk); #1;
    endtask

    // One op per cycle with out_ready high: shift/sign boundaries and the rest of the map.
    task automatic test_back_to_back();
        logic [5:0]  c  [18] = '{6'b001010, 6'b001000, 6'b011100, 6'b011011, 6'b001001, 6'b001000,
                                 6'b001010, 6'b001001, 6'b001011, 6'b000111, 6'b111010, 6'b101011,
                                 6'b101011, 6'b111111, 6'b000011, 6'b000100, 6'b000101, 6'b111010};
        logic [31:0] a  [18] = '{32'h8000_0000, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5, 32'd5, 32'd4,
                                 32'd7, 32'd3, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'd6};
        logic [31:0] b  [18] = '{32'd40, 32'd31, 32'h0, 32'h0, 32'd32, 32'd32,
                                 32'd4, 32'd4, 32'd3, 32'hFFFF_FFFF, 32'd5, 32'd5,
                                 32'd7, 32'd4, 32'hFF00, 32'hFF00, 32'hFF00, 32'd5};
        logic [31:0] ez [18] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0,
                                 32'hF800_0000, 32'h0800_0000, 32'd3, 32'hFFFF_FFFF, 32'h0, 32'h0,
                                 32'h0, 32'h0, 32'hF000, 32'hFFF0, 32'h0FF0, 32'h0};
        logic        ec [18] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            code = c[i]; X = a[i]; Y = b[i]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", i, in_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || Z !== ez[i] || CMP_Flag !== ec[i]) begin
                errors++;
                $display("FAIL b2b_op[%0d] code=%b: ov=%b Z=%h cmp=%b required 1 %h %b",
                         i, c[i], out_valid, Z, CMP_Flag, ez[i], ec[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_mul();
        int pulses = 0;
        logic [31:0] zs = '0;
        out_ready = 1'b1;
        issue(6'b000010, 32'h0000_0123, 32'h0000_0456);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || Z !== 32'h0) begin
            errors++;
            $display("FAIL mid_mul_reset: busy=%b ov=%b rdy=%b Z=%h required 0 0 0 0", busy, out_valid, in_ready, Z);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(6'b000111, 32'd2, 32'd9);
        for (int i = 0; i < 50; i++) begin
            if (out_valid === 1'b1) begin
                pulses++;
                zs = Z;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (pulses != 1 || zs !== 32'd9) begin
            errors++;
            $display("FAIL max_after_reset: pulses=%0d Z=%h required 1 00000009", pulses, zs);
        end
    endtask

    function automatic void ref16(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] z, output logic f);
        z = '0;
        f = 1'b0;
        case (c)
            6'b000000: z = a + b;
            6'b000001: z = a - b;
            6'b000010: z = a * b;
            6'b000011: z = a & b;
            6'b000100: z = a | b;
            6'b000101: z = a ^ b;
            6'b000110: z = ~b;
            6'b000111: z = (a >= b) ? a : b;
            6'b001000: z = (b > 16'd15) ? 16'h0 : (a << b);
            6'b001001: z = (b > 16'd15) ? 16'h0 : (a >> b);
            6'b001010: for (int i = 0; i < 16; i++)
                           z[i] = (b > 16'd15 || i + int'(b) > 15) ? a[15] : a[i + int'(b)];
            6'b001011: z = (a <= b) ? a : b;
            6'b111010: f = !(a > b);
            6'b101011: f = (a == b);
            6'b011011: f = (a < b);
            6'b011100: f = (a[15] != b[15]) ? a[15] : (a < b);
            default:   ;
        endcase
    endfunction

    task automatic test_param16();
        int lat = 0;
        logic [5:0] ops [17] = '{6'b000000, 6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                                 6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001010, 6'b001011,
                                 6'b111010, 6'b101011, 6'b011011, 6'b011100, 6'b110001};
        logic [15:0] ez;
        logic        ef;
        int          bad_ops = 0;
        out_ready_h = 1'b1;
        code_h = 6'b000010; x_h = 16'h00FF; y_h = 16'h0101; in_valid_h = 1'b1;
        @(posedge clk); #1;
        in_valid_h = 1'b0;
        while (lat < 50) begin
            @(posedge clk); #1; lat++;
            if (out_valid_h === 1'b1) break;
        end
        checks++;
        if (lat != 5 || z_h !== 16'hFFFF) begin
            errors++;
            $display("FAIL mul16: latency=%0d Z=%h required 5 ffff", lat, z_h);
        end
        @(posedge clk); #1;
        out_ready_h = 1'b0;
        for (int k = 0; k < 400; k++) begin
            int n = 0;
            int stall;
            code_h = ops[$urandom_range(0, 16)];
            x_h = 16'($urandom);
            y_h = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            ref16(code_h, x_h, y_h, ez, ef);
            in_valid_h = 1'b1;
            @(posedge clk); #1;
            in_valid_h = 1'b0;
            x_h = ~x_h; y_h = ~y_h;
            while (out_valid_h !== 1'b1 && n < 20) begin
                @(posedge clk); #1; n++;
            end
            stall = $urandom_range(0, 3);
            checks++;
            if (out_valid_h !== 1'b1 || z_h !== ez || cmp_h !== ef) begin
                errors++;
                bad_ops++;
                if (bad_ops <= 10)
                    $display("FAIL rand16[%0d] code=%b: ov=%b Z=%h cmp=%b required 1 %h %b",
                             k, code_h, out_valid_h, z_h, cmp_h, ez, ef);
            end
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
            end
            checks++;
            if (out_valid_h !== 1'b1 || z_h !== ez || cmp_h !== ef || in_ready_h !== 1'b0) begin
                errors++;
                bad_ops++;
                if (bad_ops <= 10)
                    $display("FAIL rand16_hold[%0d]: ov=%b Z=%h cmp=%b rdy=%b required 1 %h %b 0",
                             k, out_valid_h, z_h, cmp_h, in_ready_h, ez, ef);
            end
            out_ready_h = 1'b1;
            @(posedge clk); #1;
            out_ready_h = 1'b0;
            checks++;
            if (out_valid_h !== 1'b0) begin
                errors++;
                bad_ops++;
                if (bad_ops <= 10)
                    $display("FAIL rand16_drain[%0d]: out_valid=%b required 0", k, out_valid_h);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mul_latency();
        test_stall();
        test_back_to_back();
        test_reset_mid_mul();
        test_param16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
